// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Pipelined integer adder/subtractor with C/V/N/Z flags. The carry chain
//   is split into STAGES chunks of CW = WIDTH/STAGES bits. Each stage adds
//   one chunk and registers the carry.
//
//   Parameters: WIDTH (>= 2), STAGES (WIDTH % STAGES == 0)
//   Optional:   `define ADDSUB_SAT_EN clamps the sum to max-positive or
//               min-negative on signed overflow and raises sat for that beat.
//               Without it, the sum wraps and sat is tied to 0.
//
//   Ports:
//     clk, rst_n          rising-edge clock, synchronous active-low reset
//     in_valid/in_ready   operand handshake (a, b, sub)
//     a, b                operands; sub = 1 selects a - b
//     out_valid/out_ready result handshake
//     sum                 result
//     c_out               carry out of MSB (for sub, 1 = no borrow)
//     v_flag, n_flag,     signed overflow, sum MSB, sum == 0
//     z_flag
//     sat                 saturation occurred
module pipelined_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             v_flag,
  output logic             n_flag,
  output logic             z_flag,
  output logic             sat
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Per-stage registers. as_q packs finished sum chunks (low) with
  // not-yet-added A chunks (high). bq_q keeps the remaining b_eff chunks,
  // shifted down so the next chunk to add always sits at [CW-1:0].
  logic [WIDTH-1:0] as_q  [STAGES];
  logic [WIDTH-1:0] as_d  [STAGES];
  logic [WIDTH-1:0] bq_q  [STAGES];
  logic [WIDTH-1:0] bq_d  [STAGES];
  logic             vld_q [STAGES];
  logic             vld_d [STAGES];
  logic             cy_q  [STAGES];
  logic             cy_d  [STAGES];
  logic             z_q   [STAGES];
  logic             z_d   [STAGES];
  logic             ovf_q;
  logic             ovf_d;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] as_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             z_in;
  logic             vld_in;
  logic [CW-1:0]    chunk;
  logic             cy;
  logic             a_msb;
  logic             b_msb;

  assign adv      = !vld_q[LAST] || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;

  always_comb begin
    as_in  = '0;
    b_in   = '0;
    c_in   = 1'b0;
    z_in   = 1'b0;
    vld_in = 1'b0;
    chunk  = '0;
    cy     = 1'b0;
    a_msb  = 1'b0;
    b_msb  = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        as_in  = a;
        b_in   = b_eff;
        c_in   = sub;
        z_in   = 1'b1;
        vld_in = in_valid;
      end else begin
        as_in  = as_q[k-1];
        b_in   = bq_q[k-1];
        c_in   = cy_q[k-1];
        z_in   = z_q[k-1];
        vld_in = vld_q[k-1];
      end
      {cy, chunk} = (CW+1)'(as_in[k*CW +: CW]) + (CW+1)'(b_in[CW-1:0])
                  + (CW+1)'(c_in);
      as_d[k]             = as_in;
      as_d[k][k*CW +: CW] = chunk;
      bq_d[k]             = b_in >> CW;
      cy_d[k]             = cy;
      z_d[k]              = z_in && (chunk == '0);
      vld_d[k]            = vld_in;
      if (k == LAST) begin
        // Top chunk of A and b_eff are still in the last stage's inputs.
        a_msb = as_in[WIDTH-1];
        b_msb = b_in[CW-1];
      end
    end
    ovf_d = (a_msb == b_msb) && (as_d[LAST][WIDTH-1] != a_msb);
`ifdef ADDSUB_SAT_EN
    if (ovf_d) begin
      as_d[LAST] = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      z_d[LAST]  = 1'b0;
    end
`endif
  end

`ifdef ADDSUB_SAT_EN
  logic sat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (adv) begin
      sat_q <= ovf_d;
    end
  end

  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        as_q[k]  <= '0;
        bq_q[k]  <= '0;
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        z_q[k]   <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        as_q[k]  <= as_d[k];
        bq_q[k]  <= bq_d[k];
        vld_q[k] <= vld_d[k];
        cy_q[k]  <= cy_d[k];
        z_q[k]   <= z_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = vld_q[LAST];
  assign sum       = as_q[LAST];
  assign c_out     = cy_q[LAST];
  assign v_flag    = ovf_q;
  assign n_flag    = as_q[LAST][WIDTH-1];
  assign z_flag    = z_q[LAST];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub (WIDTH = 64, STAGES = 4).
module tb_pipelined_addsub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        c_out;
  logic        v_flag;
  logic        n_flag;
  logic        z_flag;
  logic        sat;

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_addsub #(.WIDTH(64), .STAGES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .v_flag   (v_flag),
    .n_flag   (n_flag),
    .z_flag   (z_flag),
    .sat      (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat: checks exact 4-edge latency and all result fields.
  task automatic run_one(input string tag, input logic [63:0] ai, input logic [63:0] bi,
                         input logic si, input logic [63:0] es, input logic ec,
                         input logic ev, input logic en, input logic ez, input logic esat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = ai;
    b         = bi;
    sub       = si;
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    step();
    step();
    chk({tag, "_early"}, 64'(out_valid), 64'd0);
    step();
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_c"}, 64'(c_out), 64'(ec));
    chk({tag, "_v"}, 64'(v_flag), 64'(ev));
    chk({tag, "_n"}, 64'(n_flag), 64'(en));
    chk({tag, "_z"}, 64'(z_flag), 64'(ez));
    chk({tag, "_sat"}, 64'(sat), 64'(esat));
    step();
    chk({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  logic [63:0] ms_a [3];
  logic [63:0] ms_b [3];
  logic        ms_s [3];
  logic [63:0] ms_e [3];
  logic        ms_c [3];

  initial begin
    int          sent;
    int          rcvd;
    int          stall;
    bit          stalled_done;
    logic [63:0] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_flags", {59'd0, c_out, v_flag, n_flag, z_flag, sat}, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

`ifdef ADDSUB_SAT_EN
    run_one("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_one("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b1,
            64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
`else
    run_one("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
            64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_one("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b1,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    run_one("sub_zero", 64'd5, 64'd5, 1'b1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_one("sub_borrow", 64'd0, 64'd1, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_one("chunk_carry", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0,
            64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("wrap_zero", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
            64'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_one("max_pos", 64'h7FFF_FFFF_FFFF_FFFE, 64'd1, 1'b0,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back beats with the mode changing per beat.
    ms_a[0] = 64'd10; ms_b[0] = 64'd3;  ms_s[0] = 1'b0; ms_e[0] = 64'd13;  ms_c[0] = 1'b0;
    ms_a[1] = 64'd10; ms_b[1] = 64'd3;  ms_s[1] = 1'b1; ms_e[1] = 64'd7;   ms_c[1] = 1'b1;
    ms_a[2] = 64'd3;  ms_b[2] = 64'd10; ms_s[2] = 1'b1;
    ms_e[2] = 64'hFFFF_FFFF_FFFF_FFF9;  ms_c[2] = 1'b0;
    sent = 0;
    rcvd = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && rcvd < 3; cyc++) begin
      in_valid = (sent < 3);
      if (sent < 3) begin
        a   = ms_a[sent];
        b   = ms_b[sent];
        sub = ms_s[sent];
      end
      #1;
      if (out_valid && out_ready) begin
        chk($sformatf("mode_sum%0d", rcvd), sum, ms_e[rcvd]);
        chk($sformatf("mode_c%0d", rcvd), 64'(c_out), 64'(ms_c[rcvd]));
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    chk("mode_count", 64'(rcvd), 64'd3);

    // Backpressure: 6 beats, consumer stalls 3 cycles once results appear.
    sent         = 0;
    rcvd         = 0;
    stall        = 0;
    stalled_done = 1'b0;
    held         = '0;
    sub          = 1'b0;
    for (int cyc = 0; cyc < 40 && rcvd < 6; cyc++) begin
      in_valid = (sent < 6);
      a        = 64'(sent + 1);
      b        = 64'h10;
      #1;
      if (out_valid && !stalled_done) begin
        stall        = 3;
        stalled_done = 1'b1;
        held         = sum;
      end
      out_ready = (stall == 0);
      #1;
      if (stall > 0) begin
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_sum", sum, held);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp_sum%0d", rcvd), sum, 64'h11 + 64'(rcvd));
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      step();
      if (stall > 0) stall--;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 64'(rcvd), 64'd6);
    chk("bp_sent", 64'(sent), 64'd6);
    #1;
    chk("bp_no_dup", 64'(out_valid), 64'd0);

    // Reset with three beats in flight.
    sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a        = 64'(100 + i);
      b        = 64'd1;
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", sum, 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    run_one("post_rst", 64'd7, 64'd8, 1'b0, 64'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("post_rst_quiet", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
